// File: rtl/beta_trap_pkg.sv
// Shared encodings for the beta trap controller: FSM states, per-source trap codes
// and full 32-bit mcause values.
package beta_trap_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StCsrWr,
    StRedirect
  } trap_state_e;

  localparam logic [1:0] TCU_NOTRAP    = 2'd0;
  localparam logic [1:0] TCU_INTERRUPT = 2'd1;
  localparam logic [1:0] TCU_EXCEPTION = 2'd2;

  localparam logic [1:0] INSTR_NOTRAP        = 2'd0;
  localparam logic [1:0] INSTR_MISALIG_FETCH = 2'd1;
  localparam logic [1:0] INSTR_ILLEGAL       = 2'd2;

  localparam logic [1:0] LSU_NOTRAP         = 2'd0;
  localparam logic [1:0] LSU_MISALIG_LOAD   = 2'd1;
  localparam logic [1:0] LSU_MISALIG_STORE  = 2'd2;

  localparam logic [1:0] SYNC_NOTRAP = 2'd0;
  localparam logic [1:0] SYNC_ECALL  = 2'd1;
  localparam logic [1:0] SYNC_MRET   = 2'd2;

  localparam logic [31:0] CAUSE_MISALIG_FETCH = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL       = 32'd2;
  localparam logic [31:0] CAUSE_MISALIG_LOAD  = 32'd4;
  localparam logic [31:0] CAUSE_MISALIG_STORE = 32'd6;
  localparam logic [31:0] CAUSE_ECALL_M       = 32'd11;
  localparam logic [31:0] CAUSE_IRQ_SW        = 32'h8000_0003;
  localparam logic [31:0] CAUSE_IRQ_TIMER     = 32'h8000_0007;
  localparam logic [31:0] CAUSE_IRQ_EXT       = 32'h8000_000B;

  localparam int unsigned LOCAL_IRQ_BASE = 16;

  function automatic logic [31:0] irq_mcause(input logic [4:0] code);
    return {1'b1, 26'b0, code};
  endfunction

endpackage

// File: rtl/beta_trap_irq_arbiter.sv
// Combinational machine-interrupt arbiter: MEI > MSI > MTI > local (lowest index first).
module beta_trap_irq_arbiter
  import beta_trap_pkg::*;
#(
  parameter int unsigned NUM_LOCAL_IRQ = 16
) (
  input  logic                     irq_sw_i,
  input  logic                     irq_timer_i,
  input  logic                     irq_ext_i,
  input  logic [NUM_LOCAL_IRQ-1:0] irq_local_i,
  input  logic [31:0]              mie_i,
  output logic                     irq_valid_o,
  output logic [4:0]               irq_code_o
);

  logic [31:0] pending;
  logic [31:0] enabled;

  always_comb begin
    pending     = '0;
    pending[3]  = irq_sw_i;
    pending[7]  = irq_timer_i;
    pending[11] = irq_ext_i;
    for (int unsigned i = 0; i < NUM_LOCAL_IRQ; i++) begin
      pending[LOCAL_IRQ_BASE + i] = irq_local_i[i];
    end
  end

  assign enabled = pending & mie_i;

  // Later assignments win, so sources are visited from lowest to highest priority.
  always_comb begin
    irq_valid_o = |enabled;
    irq_code_o  = '0;
    for (int i = 31; i >= 16; i--) begin
      if (enabled[i]) irq_code_o = 5'(i);
    end
    if (enabled[7])  irq_code_o = CAUSE_IRQ_TIMER[4:0];
    if (enabled[3])  irq_code_o = CAUSE_IRQ_SW[4:0];
    if (enabled[11]) irq_code_o = CAUSE_IRQ_EXT[4:0];
  end

endmodule

// File: rtl/beta_trap_ctrl.sv
// Machine-mode trap control unit: takes exceptions, interrupts and MRET at the commit
// point, flushes the pipe, writes trap CSRs and redirects fetch.
module beta_trap_ctrl
  import beta_trap_pkg::*;
#(
  parameter int unsigned NUM_LOCAL_IRQ = 16,
  parameter bit          VECTORED_EN   = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     instr_valid_i,
  input  logic [1:0]               instr_trap_i,
  input  logic [1:0]               lsu_trap_i,
  input  logic [1:0]               sync_trap_i,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              badaddr_i,
  input  logic                     irq_sw_i,
  input  logic                     irq_timer_i,
  input  logic                     irq_ext_i,
  input  logic [NUM_LOCAL_IRQ-1:0] irq_local_i,
  input  logic                     mstatus_mie_i,
  input  logic [31:0]              mie_i,
  input  logic [31:0]              mtvec_i,
  input  logic [31:0]              mepc_i,
  input  logic                     pipe_drained_i,
  output logic                     flush_o,
  output logic                     csr_we_o,
  output logic [31:0]              mcause_o,
  output logic [31:0]              mepc_o,
  output logic [31:0]              mtval_o,
  output logic                     redirect_valid_o,
  output logic [31:0]              redirect_pc_o,
  input  logic                     redirect_ready_i,
  output logic [1:0]               trap_type_o,
  output logic                     mret_o
);

  trap_state_e state_q, state_d;
  logic [31:0] mcause_q, mepc_q, mtval_q, target_q;
  logic [1:0]  type_q;
  logic        mret_q;

  logic        exc_valid, exc_has_tval;
  logic [31:0] exc_cause;
  logic        irq_valid;
  logic [4:0]  irq_code;
  logic        take_exc, take_irq, take_mret, take_any;
  logic [31:0] trap_base, trap_target;

  beta_trap_irq_arbiter #(
    .NUM_LOCAL_IRQ (NUM_LOCAL_IRQ)
  ) u_irq_arbiter (
    .irq_sw_i    (irq_sw_i),
    .irq_timer_i (irq_timer_i),
    .irq_ext_i   (irq_ext_i),
    .irq_local_i (irq_local_i),
    .mie_i       (mie_i),
    .irq_valid_o (irq_valid),
    .irq_code_o  (irq_code)
  );

  always_comb begin
    exc_valid    = 1'b1;
    exc_has_tval = 1'b1;
    exc_cause    = CAUSE_ILLEGAL;
    if (instr_trap_i == INSTR_ILLEGAL) begin
      exc_cause = CAUSE_ILLEGAL;
    end else if (instr_trap_i == INSTR_MISALIG_FETCH) begin
      exc_cause = CAUSE_MISALIG_FETCH;
    end else if (sync_trap_i == SYNC_ECALL) begin
      exc_cause    = CAUSE_ECALL_M;
      exc_has_tval = 1'b0;
    end else if (lsu_trap_i == LSU_MISALIG_LOAD) begin
      exc_cause = CAUSE_MISALIG_LOAD;
    end else if (lsu_trap_i == LSU_MISALIG_STORE) begin
      exc_cause = CAUSE_MISALIG_STORE;
    end else if (instr_trap_i != INSTR_NOTRAP || lsu_trap_i != LSU_NOTRAP ||
                 (sync_trap_i != SYNC_NOTRAP && sync_trap_i != SYNC_MRET)) begin
      // Unassigned codes are still traps; report them as illegal instructions.
      exc_cause = CAUSE_ILLEGAL;
    end else begin
      exc_valid = 1'b0;
    end
  end

  assign take_exc  = (state_q == StIdle) && instr_valid_i && exc_valid;
  assign take_irq  = (state_q == StIdle) && instr_valid_i && !exc_valid &&
                     mstatus_mie_i && irq_valid;
  assign take_mret = (state_q == StIdle) && instr_valid_i && !exc_valid && !take_irq &&
                     (sync_trap_i == SYNC_MRET);
  assign take_any  = take_exc || take_irq || take_mret;

  assign trap_base   = {mtvec_i[31:2], 2'b00};
  assign trap_target = (take_irq && VECTORED_EN && mtvec_i[1:0] == 2'b01) ?
                       trap_base + {25'b0, irq_code, 2'b00} : trap_base;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (take_any) state_d = StFlush;
      StFlush:    if (pipe_drained_i) state_d = mret_q ? StRedirect : StCsrWr;
      StCsrWr:    state_d = StRedirect;
      StRedirect: if (redirect_ready_i) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      mcause_q <= '0;
      mepc_q   <= '0;
      mtval_q  <= '0;
      target_q <= '0;
      type_q   <= TCU_NOTRAP;
      mret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_any) begin
        mret_q   <= take_mret;
        target_q <= take_mret ? mepc_i : trap_target;
        type_q   <= take_exc ? TCU_EXCEPTION : (take_irq ? TCU_INTERRUPT : TCU_NOTRAP);
      end
      // MRET leaves the trap CSR image of the last trap untouched.
      if (take_exc || take_irq) begin
        mcause_q <= take_exc ? exc_cause : irq_mcause(irq_code);
        mepc_q   <= pc_i;
        mtval_q  <= (take_exc && exc_has_tval) ? badaddr_i : '0;
      end
    end
  end

  assign flush_o          = (state_q == StFlush);
  assign csr_we_o         = (state_q == StCsrWr);
  assign redirect_valid_o = (state_q == StRedirect);
  assign redirect_pc_o    = redirect_valid_o ? target_q : '0;
  assign mret_o           = redirect_valid_o && mret_q && redirect_ready_i;
  assign trap_type_o      = (state_q == StIdle) ? TCU_NOTRAP : type_q;
  assign mcause_o         = mcause_q;
  assign mepc_o           = mepc_q;
  assign mtval_o          = mtval_q;

endmodule

// File: tb/tb_beta_trap_ctrl.sv
// Self-checking bench for beta_trap_ctrl: directed vector table, reset corner cases and
// randomized traps checked against a priority-list reference model.
module tb_beta_trap_ctrl;
  import beta_trap_pkg::*;

  localparam int unsigned NLOC = 16;

  typedef struct packed {
    logic        valid;
    logic [1:0]  instr;
    logic [1:0]  lsu;
    logic [1:0]  sync;
    logic [31:0] pc;
    logic [31:0] bad;
    logic        sw;
    logic        tim;
    logic        ext;
    logic [15:0] loc;
    logic        mstat;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
  } vec_t;

  typedef struct packed {
    logic        take;
    logic        mret;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [1:0]  ttype;
    logic [31:0] target;
  } exp_t;

  typedef struct {
    string name;
    vec_t  v;
    exp_t  e;
    int    dl;
    int    rl;
  } row_t;

  logic clk = 1'b0;
  logic rst_ni;
  logic instr_valid_i;
  logic [1:0] instr_trap_i, lsu_trap_i, sync_trap_i;
  logic [31:0] pc_i, badaddr_i, mie_i, mtvec_i, mepc_i;
  logic irq_sw_i, irq_timer_i, irq_ext_i, mstatus_mie_i, pipe_drained_i, redirect_ready_i;
  logic [NLOC-1:0] irq_local_i;
  logic flush_o, csr_we_o, redirect_valid_o, mret_o;
  logic [31:0] mcause_o, mepc_o, mtval_o, redirect_pc_o;
  logic [1:0] trap_type_o;

  int checks = 0;
  int failures = 0;
  row_t tbl[$];

  always #5 clk = ~clk;

  beta_trap_ctrl #(
    .NUM_LOCAL_IRQ (NLOC),
    .VECTORED_EN   (1'b1)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .instr_valid_i    (instr_valid_i),
    .instr_trap_i     (instr_trap_i),
    .lsu_trap_i       (lsu_trap_i),
    .sync_trap_i      (sync_trap_i),
    .pc_i             (pc_i),
    .badaddr_i        (badaddr_i),
    .irq_sw_i         (irq_sw_i),
    .irq_timer_i      (irq_timer_i),
    .irq_ext_i        (irq_ext_i),
    .irq_local_i      (irq_local_i),
    .mstatus_mie_i    (mstatus_mie_i),
    .mie_i            (mie_i),
    .mtvec_i          (mtvec_i),
    .mepc_i           (mepc_i),
    .pipe_drained_i   (pipe_drained_i),
    .flush_o          (flush_o),
    .csr_we_o         (csr_we_o),
    .mcause_o         (mcause_o),
    .mepc_o           (mepc_o),
    .mtval_o          (mtval_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i),
    .trap_type_o      (trap_type_o),
    .mret_o           (mret_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    instr_valid_i = v.valid;
    instr_trap_i  = v.instr;
    lsu_trap_i    = v.lsu;
    sync_trap_i   = v.sync;
    pc_i          = v.pc;
    badaddr_i     = v.bad;
    irq_sw_i      = v.sw;
    irq_timer_i   = v.tim;
    irq_ext_i     = v.ext;
    irq_local_i   = v.loc;
    mstatus_mie_i = v.mstat;
    mie_i         = v.mie;
    mtvec_i       = v.mtvec;
    mepc_i        = v.mepc;
  endtask

  // Noise on every trap-side input while a sequence is in flight; all of it must be ignored.
  task automatic drive_junk();
    vec_t j;
    j = vec_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    j.valid = 1'b1;
    j.mstat = 1'b1;
    apply_vec(j);
  endtask

  function automatic exp_t mk_exp(input logic take, input logic mret, input logic [31:0] mcause,
                                  input logic [31:0] mtval, input logic [1:0] ttype,
                                  input logic [31:0] target);
    exp_t e;
    e.take = take; e.mret = mret; e.mcause = mcause;
    e.mtval = mtval; e.ttype = ttype; e.target = target;
    return e;
  endfunction

  // Reference: walk the architectural priority lists directly.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    int code;
    logic [31:0] pend, en, base;
    int order[$];
    e = '0;
    if (!v.valid) return e;
    base = v.mtvec & 32'hFFFF_FFFC;
    code = -1;
    if (v.instr == INSTR_ILLEGAL)            code = 2;
    else if (v.instr == INSTR_MISALIG_FETCH) code = 0;
    else if (v.sync == SYNC_ECALL)           code = 11;
    else if (v.lsu == LSU_MISALIG_LOAD)      code = 4;
    else if (v.lsu == LSU_MISALIG_STORE)     code = 6;
    if (code >= 0) begin
      return mk_exp(1'b1, 1'b0, 32'(code), (code == 11) ? 32'h0 : v.bad, TCU_EXCEPTION, base);
    end
    pend = 32'h0;
    if (v.sw)  pend = pend | (32'h1 << 3);
    if (v.tim) pend = pend | (32'h1 << 7);
    if (v.ext) pend = pend | (32'h1 << 11);
    for (int i = 0; i < 16; i++) if (v.loc[i]) pend = pend | (32'h1 << (16 + i));
    en = pend & v.mie;
    if (v.mstat && en != 0) begin
      order = {11, 3, 7};
      for (int i = 16; i < 32; i++) order.push_back(i);
      foreach (order[k]) begin
        if (code < 0 && en[order[k]]) code = order[k];
      end
      return mk_exp(1'b1, 1'b0, 32'h8000_0000 + 32'(code), 32'h0, TCU_INTERRUPT,
                    base + ((v.mtvec[1:0] == 2'b01) ? 32'(4 * code) : 32'h0));
    end
    if (v.sync == SYNC_MRET) return mk_exp(1'b1, 1'b1, 32'h0, 32'h0, TCU_NOTRAP, v.mepc);
    return e;
  endfunction

  // Entered at posedge+1 in IDLE; leaves at posedge+1 back in IDLE.
  task automatic run_seq(input string name, input vec_t v, input exp_t e, input int dl,
                         input int rl);
    int nf, nc, nr, nm, cyc;
    bit done;
    apply_vec(v);
    @(posedge clk); #1;
    if (!e.take) begin
      apply_vec('0);
      check({name, ".no_trap_flush"}, 32'(flush_o), 32'h0);
      check({name, ".no_trap_type"}, 32'(trap_type_o), 32'(TCU_NOTRAP));
      return;
    end
    nf = 0; nc = 0; nr = 0; nm = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      redirect_ready_i = 1'b0;
      drive_junk();
      if (flush_o) begin
        nf++;
        if (nf == 1) check({name, ".type"}, 32'(trap_type_o), 32'(e.ttype));
      end
      pipe_drained_i = flush_o && (nf >= dl);
      if (csr_we_o) begin
        nc++;
        check({name, ".mcause"}, mcause_o, e.mcause);
        check({name, ".mepc"}, mepc_o, v.pc);
        check({name, ".mtval"}, mtval_o, e.mtval);
      end
      if (redirect_valid_o) begin
        nr++;
        check({name, ".redirect_pc"}, redirect_pc_o, e.target);
        if (nr > rl) begin
          redirect_ready_i = 1'b1;
          apply_vec('0);
          done = 1'b1;
        end
      end
      #1;
      if (mret_o) nm++;
      @(posedge clk); #1;
      cyc++;
    end
    redirect_ready_i = 1'b0;
    pipe_drained_i   = 1'b0;
    apply_vec('0);
    check({name, ".completed"}, 32'(done), 32'h1);
    check({name, ".flush_cycles"}, 32'(nf), 32'(dl));
    check({name, ".csr_we_pulses"}, 32'(nc), e.mret ? 32'h0 : 32'h1);
    check({name, ".mret_pulses"}, 32'(nm), e.mret ? 32'h1 : 32'h0);
    check({name, ".idle_type"}, 32'(trap_type_o), 32'(TCU_NOTRAP));
    check({name, ".idle_redirect"}, 32'(redirect_valid_o), 32'h0);
    if (!e.mret) begin
      check({name, ".held_mcause"}, mcause_o, e.mcause);
      check({name, ".held_mtval"}, mtval_o, e.mtval);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".flush"}, 32'(flush_o), 32'h0);
    check({name, ".csr_we"}, 32'(csr_we_o), 32'h0);
    check({name, ".mcause"}, mcause_o, 32'h0);
    check({name, ".mepc"}, mepc_o, 32'h0);
    check({name, ".mtval"}, mtval_o, 32'h0);
    check({name, ".redirect_valid"}, 32'(redirect_valid_o), 32'h0);
    check({name, ".redirect_pc"}, redirect_pc_o, 32'h0);
    check({name, ".trap_type"}, 32'(trap_type_o), 32'h0);
    check({name, ".mret"}, 32'(mret_o), 32'h0);
  endtask

  task automatic add_row(input string name, input vec_t v, input exp_t e, input int dl,
                         input int rl);
    row_t r;
    r.name = name; r.v = v; r.e = e; r.dl = dl; r.rl = rl;
    tbl.push_back(r);
  endtask

  initial begin
    vec_t v;
    exp_t e;

    v = '0; v.valid = 1; v.lsu = LSU_MISALIG_LOAD; v.pc = 32'h100; v.bad = 32'h2003;
    v.mtvec = 32'h8000;
    add_row("load_mis", v, mk_exp(1, 0, 32'h4, 32'h2003, TCU_EXCEPTION, 32'h8000), 1, 0);
    v = '0; v.valid = 1; v.tim = 1; v.mie = 32'h80; v.mstat = 1; v.mtvec = 32'h8001;
    v.pc = 32'h200;
    add_row("timer_vec", v, mk_exp(1, 0, 32'h8000_0007, 0, TCU_INTERRUPT, 32'h801C), 2, 1);
    v = '0; v.valid = 1; v.ext = 1; v.loc = 16'h4; v.mie = 32'h0004_0800; v.mstat = 1;
    v.mtvec = 32'h8001; v.pc = 32'h300;
    add_row("ext_over_local", v, mk_exp(1, 0, 32'h8000_000B, 0, TCU_INTERRUPT, 32'h802C), 1, 0);
    v.ext = 0;
    add_row("local2", v, mk_exp(1, 0, 32'h8000_0012, 0, TCU_INTERRUPT, 32'h8048), 1, 0);
    v = '0; v.valid = 1; v.instr = INSTR_ILLEGAL; v.sync = SYNC_ECALL; v.ext = 1;
    v.mie = 32'h800; v.mstat = 1; v.bad = 32'hDEAD_BEEF; v.mtvec = 32'h8001; v.pc = 32'h44;
    add_row("illegal_ecall_irq", v,
            mk_exp(1, 0, 32'h2, 32'hDEAD_BEEF, TCU_EXCEPTION, 32'h8000), 1, 0);
    v = '0; v.valid = 1; v.sync = SYNC_MRET; v.mepc = 32'h400; v.mtvec = 32'h8000;
    add_row("mret", v, mk_exp(1, 1, 0, 0, TCU_NOTRAP, 32'h400), 3, 2);
    v = '0; v.valid = 1; v.sync = SYNC_ECALL; v.bad = 32'h1234; v.pc = 32'h88;
    v.mtvec = 32'h9000;
    add_row("ecall", v, mk_exp(1, 0, 32'd11, 0, TCU_EXCEPTION, 32'h9000), 1, 1);
    v = '0; v.valid = 1; v.instr = INSTR_MISALIG_FETCH; v.lsu = LSU_MISALIG_LOAD;
    v.bad = 32'h0000_0102; v.mtvec = 32'h9002;
    add_row("fetch_over_load", v, mk_exp(1, 0, 32'd0, 32'h102, TCU_EXCEPTION, 32'h9000), 2, 0);
    v = '0; v.valid = 1; v.lsu = LSU_MISALIG_STORE; v.pc = 32'h300; v.bad = 32'h7;
    v.mtvec = 32'hA000;
    add_row("store_mis", v, mk_exp(1, 0, 32'd6, 32'h7, TCU_EXCEPTION, 32'hA000), 1, 0);
    v = '0; v.valid = 1; v.sync = SYNC_MRET; v.tim = 1; v.mie = 32'h80; v.mstat = 0;
    v.mepc = 32'h5554;
    add_row("masked_irq_mret", v, mk_exp(1, 1, 0, 0, TCU_NOTRAP, 32'h5554), 1, 0);
    v = '0; v.valid = 1; v.tim = 1; v.mie = 32'h80; v.mstat = 1; v.mtvec = 32'h8003;
    add_row("mode3_direct", v, mk_exp(1, 0, 32'h8000_0007, 0, TCU_INTERRUPT, 32'h8000), 1, 0);
    v = '0; v.valid = 1; v.ext = 1; v.mie = 32'h800; v.mstat = 1; v.mtvec = 32'hFFFF_FFF1;
    add_row("vec_wrap", v, mk_exp(1, 0, 32'h8000_000B, 0, TCU_INTERRUPT, 32'h1C), 1, 0);
    v = '0; v.valid = 1; v.sw = 1; v.tim = 1; v.mie = 32'h88; v.mstat = 1; v.mtvec = 32'h100;
    add_row("sw_over_timer", v, mk_exp(1, 0, 32'h8000_0003, 0, TCU_INTERRUPT, 32'h100), 1, 0);
    v = '0; v.valid = 0; v.lsu = LSU_MISALIG_LOAD;
    add_row("invalid_instr", v, '0, 1, 0);

    rst_ni = 1'b0;
    pipe_drained_i = 1'b0;
    redirect_ready_i = 1'b0;
    apply_vec('0);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_ni = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_seq(tbl[i].name, tbl[i].v, tbl[i].e, tbl[i].dl, tbl[i].rl);

    // Reset while flushing aborts the sequence and clears everything latched.
    apply_vec(tbl[0].v);
    @(posedge clk); #1;
    apply_vec('0);
    check("rst_flush.in_flush", 32'(flush_o), 32'h1);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    check_all_zero("rst_flush");
    rst_ni = 1'b1;
    @(posedge clk); #1;
    check("rst_flush.stays_idle", 32'(flush_o), 32'h0);

    for (int n = 0; n < 200; n++) begin
      v = vec_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      v.valid = ($urandom_range(0, 7) != 0);
      v.instr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : INSTR_NOTRAP;
      v.lsu   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : LSU_NOTRAP;
      v.sync  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 2)) : SYNC_NOTRAP;
      v.loc   = ($urandom_range(0, 1) == 0) ? 16'h0 : v.loc;
      e = model(v);
      run_seq($sformatf("rand%0d", n), v, e, $urandom_range(1, 3), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
